ifetch_ctrl: RTL and testbench
==============================

// Module: ifetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer for the 5-stage RV32I pipeline. Owns the PC and drives the word-aligned, combinational instruction-memory read port.
//  Buffers fetched words in a small prefetch queue and hands {pc, instr} to the IF/ID register through a valid/ready handshake.
//  Handles branch/jump redirects from EX (queue flush) and stops fetching at the end of program memory.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  DEPTH      2              prefetch queue entries (power of 2, >=2)
//  IMEM_WORDS 32             instruction-memory size in 32-bit words; fetch range is [0, IMEM_WORDS*4)
// PORTS
//  clk            in   1   pipeline clock, rising edge
//  reset          in   1   asynchronous, active-high
//  imem_addr      out  32  byte address to imem; bits[1:0] always 0
//  imem_rdata     in   32  imem read data, valid in the same cycle as imem_addr
//  redirect_valid in   1   EX-stage taken branch/jump this cycle
//  redirect_pc    in   32  redirect target byte address
//  id_ready       in   1   decode accepts the entry at the head of the queue
//  if_valid       out  1   queue head valid
//  if_instr       out  32  queue-head instruction; NOP 32'h0000_0013 when !if_valid
//  if_pc          out  32  queue-head PC; 0 when !if_valid
//  pc_oob         out  1   PC is at or past IMEM_WORDS*4; fetch suspended
//  misalign_err   out  1   one-cycle pulse: redirect_pc[1:0] != 0
// BEHAVIOUR
//  - Reset (async): pc=RESET_PC, queue empty, if_valid=0, if_instr=NOP, if_pc=0, pc_oob=0, misalign_err=0.
//  - imem_addr = {pc[31:2],2'b00}, combinational from the pc register.
//  - Push: imem_rdata is written on the clock edge when !redirect_valid && !pc_oob && (count<DEPTH || pop). The write stores {pc, imem_rdata}, then pc<=pc+4.
//  - Pop: on the clock edge when if_valid && id_ready && !redirect_valid. Push and pop in the same cycle leave count unchanged.
//  - Throughput: one instruction per cycle when id_ready is held high. Latency from pc register to if_valid is 1 cycle.
//  - Redirect has priority over push and pop. On a redirect cycle:
//      queue flushed (count=0); pc<={redirect_pc[31:2],2'b00}; no push or pop.
//      The next cycle shows if_valid=0; the target instruction is valid the cycle after.
//  - misalign_err is asserted in the cycle following a redirect where redirect_pc[1:0]!=0. The target is still accepted with bits[1:0] forced to 0.
//  - End of memory: pc_oob = (pc >= IMEM_WORDS*4), registered with pc.
//      While pc_oob=1: no push; the queue drains normally; imem_addr holds pc.
//      pc_oob is cleared only by a redirect into range or by reset. A redirect out of range sets pc_oob immediately.
//  - pc+4 wraps modulo 2^32. The wrap boundary is never reached in practice because of pc_oob.
//  - Full queue and !id_ready: pc holds; imem_addr is stable.
//  - Reset mid-operation: all state returns to reset values asynchronously. The first push occurs on the first edge after deassertion.
// CONFIGURATION
//  IFETCH_PERF_EN defined: adds outputs perf_fetch_cnt[31:0] (pushes), perf_stall_cnt[31:0] (cycles with a push blocked by a full queue) and perf_flush_cnt[31:0] (redirects).
//    All three counters reset to 0 and saturate at 32'hFFFF_FFFF.
//  IFETCH_PERF_EN undefined: these ports and counters do not exist. Behaviour is otherwise identical.
// STRUCTURE
//  Package ifetch_pkg:
//    - NOP_INSTR = 32'h0000_0013
//    - typedef struct packed {logic [31:0] pc; logic [31:0] instr;} fetch_entry_t
//  Sub-module fetch_fifo:
//    - parameterised DEPTH, storage of fetch_entry_t
//    - push/pop/flush inputs; full/empty/count and head outputs
//    - flush has priority over push and pop
//  ifetch_ctrl holds the pc register, push/pop/redirect control, pc_oob, misalign_err and the perf counters.
// TESTING
//  1 Reset release, imem word0=0x00500093, word1=0x0040A113, id_ready=1 -> cycle 1: if_valid=1, if_pc=0, if_instr=0x00500093; cycle 2: if_pc=4, if_instr=0x0040A113.
//  2 id_ready=0 for 5 cycles -> queue fills to DEPTH, pc stops at RESET_PC+8, imem_addr stable. Release id_ready -> entries pop in order with no gap, nothing lost or duplicated.
//  3 Redirect to 0x14 while the queue is full -> next cycle if_valid=0; following cycle if_pc=0x14, if_instr=RAM[5]. Old entries never appear at the output.
//  4 Redirect to 0x22 -> misalign_err pulses for 1 cycle; fetch resumes at 0x20.
//  5 Run sequentially to 0x7C with IMEM_WORDS=32 -> 0x7C is delivered, then pc_oob=1 and the queue drains; redirect to 0x0 -> pc_oob=0 and fetch resumes at 0x0.
//  6 Assert reset mid-stream while the queue holds 2 entries -> outputs return to reset values immediately; with IFETCH_PERF_EN, all counters read 0.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package ifetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_ctrl_fetch_fifo.sv
// Prefetch queue of {pc, instr} entries; flush wins over push and pop.
module fetch_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  fetch_entry_t               wdata_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output fetch_entry_t               head_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  fetch_entry_t          mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !flush_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by overflow.
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// RV32I fetch sequencer: PC, prefetch queue control, redirects and end-of-memory stop.
// Define IFETCH_PERF_EN to add saturating fetch/stall/flush performance counters.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned IMEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        pc_oob,
  output logic        misalign_err
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam logic [32:0] PcLimit = 33'(IMEM_WORDS) * 33'd4;
  localparam int unsigned CntW    = $clog2(DEPTH + 1);

  logic [31:0]     pc_q, pc_d;
  logic            pc_oob_q, pc_oob_d;
  logic            misalign_q, misalign_d;
  logic            push, pop, fifo_full, fifo_empty;
  logic [CntW-1:0] unused_fifo_count;
  fetch_entry_t    wr_entry, head;

  assign wr_entry = '{pc: pc_q, instr: imem_rdata};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .wdata_i (wr_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (unused_fifo_count),
    .head_o  (head)
  );

  assign if_valid     = !fifo_empty;
  assign if_instr     = if_valid ? head.instr : NOP_INSTR;
  assign if_pc        = if_valid ? head.pc : 32'h0;
  assign imem_addr    = {pc_q[31:2], 2'b00};
  assign pc_oob       = pc_oob_q;
  assign misalign_err = misalign_q;

  always_comb begin
    pop  = if_valid && id_ready && !redirect_valid;
    // A full queue still accepts a push when the head leaves this cycle.
    push = !redirect_valid && !pc_oob_q && (!fifo_full || pop);
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (push) begin
      pc_d = pc_q + 32'd4;
    end
    pc_oob_d   = ({1'b0, pc_d} >= PcLimit);
    misalign_d = redirect_valid && (redirect_pc[1:0] != 2'b00);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      pc_oob_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc_oob_q   <= pc_oob_d;
      misalign_q <= misalign_d;
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic        stall;

  always_comb begin
    stall       = !redirect_valid && !pc_oob_q && fifo_full && !pop;
    fetch_cnt_d = (push && fetch_cnt_q != '1) ? fetch_cnt_q + 32'd1 : fetch_cnt_q;
    stall_cnt_d = (stall && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    flush_cnt_d = (redirect_valid && flush_cnt_q != '1) ? flush_cnt_q + 32'd1 : flush_cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed self-checking bench for ifetch_ctrl with a 32-word combinational imem model.
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_ready = 1'b0;
  logic        if_valid, pc_oob, misalign_err;
  logic [31:0] if_instr, if_pc;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt;
`endif

  logic [31:0] mem [32];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  assign imem_rdata = (imem_addr < 32'd128) ? mem[imem_addr[6:2]] : 32'hDEAD_BEEF;

  ifetch_ctrl #(
    .RESET_PC   (32'h0),
    .DEPTH      (2),
    .IMEM_WORDS (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .pc_oob         (pc_oob),
    .misalign_err   (misalign_err)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset spans one edge; the next edge is the first one after deassertion.
  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if_valid); end
    checks++; if (if_instr !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr: got %h want 00000013", if_instr); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", if_pc); end
    checks++; if (pc_oob !== 1'b0) begin errors++; $display("FAIL reset_oob: got %b want 0", pc_oob); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b want 0", misalign_err); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
  endtask

  task automatic test_first_fetch();
    id_ready = 1'b1;
    do_reset();
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h0050_0093) begin
      errors++; $display("FAIL fetch_c1: got v=%b pc=%h i=%h want v=1 pc=0 i=00500093", if_valid, if_pc, if_instr);
    end
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== 32'h0040_A113) begin
      errors++; $display("FAIL fetch_c2: got v=%b pc=%h i=%h want v=1 pc=4 i=0040a113", if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_backpressure();
    id_ready = 1'b0;
    do_reset();
    repeat (3) tick();
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL bp_addr_mid: got %h want 8", imem_addr); end
    repeat (2) tick();
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL bp_addr: got %h want 8", imem_addr); end
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin errors++; $display("FAIL bp_head: got v=%b pc=%h want v=1 pc=0", if_valid, if_pc); end
`ifdef IFETCH_PERF_EN
    checks++; if (perf_fetch_cnt !== 32'd2) begin errors++; $display("FAIL bp_perf_fetch: got %0d want 2", perf_fetch_cnt); end
    checks++; if (perf_stall_cnt !== 32'd3) begin errors++; $display("FAIL bp_perf_stall: got %0d want 3", perf_stall_cnt); end
`endif
    id_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'(i * 4) || if_instr !== mem[i]) begin
        errors++; $display("FAIL bp_drain%0d: got v=%b pc=%h i=%h want v=1 pc=%h i=%h", i, if_valid, if_pc, if_instr, i * 4, mem[i]);
      end
    end
  endtask

  task automatic test_redirect();
    id_ready = 1'b0;
    do_reset();
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h14;
    tick();
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h14) begin
      errors++; $display("FAIL redir_bubble: got v=%b addr=%h want v=0 addr=14", if_valid, imem_addr);
    end
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h14 || if_instr !== mem[5]) begin
      errors++; $display("FAIL redir_target: got v=%b pc=%h i=%h want v=1 pc=14 i=%h", if_valid, if_pc, if_instr, mem[5]);
    end
    tick();
    checks++; if (if_pc !== 32'h18) begin errors++; $display("FAIL redir_next: got %h want 18", if_pc); end
`ifdef IFETCH_PERF_EN
    checks++; if (perf_flush_cnt !== 32'd1) begin errors++; $display("FAIL redir_perf_flush: got %0d want 1", perf_flush_cnt); end
`endif
  endtask

  task automatic test_misalign();
    id_ready = 1'b1;
    do_reset();
    repeat (2) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h22;
    tick();
    redirect_valid = 1'b0;
    checks++; if (misalign_err !== 1'b1 || if_valid !== 1'b0 || imem_addr !== 32'h20) begin
      errors++; $display("FAIL mis_pulse: got err=%b v=%b addr=%h want err=1 v=0 addr=20", misalign_err, if_valid, imem_addr);
    end
    tick();
    checks++; if (misalign_err !== 1'b0 || if_pc !== 32'h20 || if_instr !== mem[8]) begin
      errors++; $display("FAIL mis_resume: got err=%b pc=%h i=%h want err=0 pc=20 i=%h", misalign_err, if_pc, if_instr, mem[8]);
    end
  endtask

  task automatic test_end_of_mem();
    id_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 32; k++) begin
      tick();
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'(k * 4) || if_instr !== mem[k]) begin
        errors++; $display("FAIL seq%0d: got v=%b pc=%h i=%h want v=1 pc=%h i=%h", k, if_valid, if_pc, if_instr, k * 4, mem[k]);
      end
    end
    checks++; if (pc_oob !== 1'b1) begin errors++; $display("FAIL oob_set: got %b want 1", pc_oob); end
    tick();
    checks++; if (if_valid !== 1'b0 || pc_oob !== 1'b1) begin
      errors++; $display("FAIL oob_drain: got v=%b oob=%b want v=0 oob=1", if_valid, pc_oob);
    end
    repeat (2) tick();
    checks++; if (imem_addr !== 32'h80 || if_valid !== 1'b0) begin
      errors++; $display("FAIL oob_hold: got addr=%h v=%b want addr=80 v=0", imem_addr, if_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    tick();
    redirect_valid = 1'b0;
    checks++; if (pc_oob !== 1'b0 || if_valid !== 1'b0) begin
      errors++; $display("FAIL oob_clear: got oob=%b v=%b want oob=0 v=0", pc_oob, if_valid);
    end
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== mem[0]) begin
      errors++; $display("FAIL oob_resume: got v=%b pc=%h i=%h want v=1 pc=0 i=%h", if_valid, if_pc, if_instr, mem[0]);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    checks++; if (pc_oob !== 1'b1 || if_valid !== 1'b0) begin
      errors++; $display("FAIL oob_redir: got oob=%b v=%b want oob=1 v=0", pc_oob, if_valid);
    end
    tick();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL oob_nofetch: got v=%b want 0", if_valid); end
  endtask

  task automatic test_reset_midstream();
    id_ready = 1'b0;
    do_reset();
    repeat (2) tick();
    checks++; if (if_valid !== 1'b1 || imem_addr !== 32'h8) begin
      errors++; $display("FAIL mid_pre: got v=%b addr=%h want v=1 addr=8", if_valid, imem_addr);
    end
    reset = 1'b1;
    #1;
    checks++; if (if_valid !== 1'b0 || if_instr !== 32'h0000_0013 || if_pc !== 32'h0) begin
      errors++; $display("FAIL mid_out: got v=%b i=%h pc=%h want v=0 i=00000013 pc=0", if_valid, if_instr, if_pc);
    end
    checks++; if (imem_addr !== 32'h0 || pc_oob !== 1'b0 || misalign_err !== 1'b0) begin
      errors++; $display("FAIL mid_state: got addr=%h oob=%b err=%b want 0 0 0", imem_addr, pc_oob, misalign_err);
    end
`ifdef IFETCH_PERF_EN
    checks++; if (perf_fetch_cnt !== 32'h0 || perf_stall_cnt !== 32'h0 || perf_flush_cnt !== 32'h0) begin
      errors++; $display("FAIL mid_perf: got %0d %0d %0d want 0 0 0", perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt);
    end
`endif
    tick();
    reset = 1'b0;
    id_ready = 1'b1;
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
      errors++; $display("FAIL mid_restart: got v=%b pc=%h want v=1 pc=0", if_valid, if_pc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0040_A113;
    for (int i = 2; i < 32; i++) mem[i] = 32'hA500_0000 + 32'(i);
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_redirect();
    test_misalign();
    test_end_of_mem();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
